// File: rtl/comp_pkg.sv
// Shared types for the small unsigned comparator family.
package comp_pkg;

    // One-hot compare result, bit order {gt, eq, lt}
    typedef enum logic [2:0] {
        CMP_GT = 3'b100,
        CMP_EQ = 3'b010,
        CMP_LT = 3'b001
    } cmp_res_t;

    // Reset result matches the all-zero operand pair
    localparam cmp_res_t CMP_RESET = CMP_EQ;

endpackage : comp_pkg

// File: rtl/comp_core.sv
// Combinational MSB-first unsigned magnitude compare of two WIDTH-bit operands.
module comp_core
    import comp_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    logic [WIDTH-1:0] bit_gt;
    logic [WIDTH-1:0] bit_eq;
    logic             gt_run;
    logic             eq_run;

    // Per-bit slice terms: this bit alone says a is greater / bits match
    assign bit_gt = a & ~b;
    assign bit_eq = ~(a ^ b);

    // Cascade from the MSB: the first differing bit decides, later bits are masked
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        gt_run = 1'b0;
        eq_run = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            gt_run = gt_run | (eq_run & bit_gt[i]);
            eq_run = eq_run & bit_eq[i];
        end
    end

    // Map the cascade result onto the one-hot encoding
    always_comb begin
        res = CMP_LT;
        if (gt_run) begin
            res = CMP_GT;
        end else if (eq_run) begin
            res = CMP_EQ;
        end
    end

endmodule : comp_core

// File: rtl/comp2_w.sv
// Registered unsigned magnitude comparator: one-cycle latency, one-hot g/e/l.
module comp2_w
    import comp_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g,
    output logic             e,
    output logic             l
);

    cmp_res_t res_d;
    cmp_res_t res_q;

    comp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (a),
        .b  (b),
        .res(res_d)
    );

    // Output register: reloads the compare every edge, forced to "equal" in reset
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) begin
            res_q <= CMP_RESET;
        end else begin
            res_q <= res_d;
        end
    end

    assign {g, e, l} = res_q;

    // The output code must stay one-hot in every cycle, reset included
    a_onehot : assert property (@(posedge clk) $onehot({g, e, l}));

endmodule : comp2_w

// File: tb/tb_comp2_w.sv
// Scoreboard bench for comp2_w: directed WIDTH=2 checks plus a random WIDTH=4 sweep.
module tb_comp2_w;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       g, e, l;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       g4, e4, l4;

    int errors = 0;
    int checks = 0;

    logic [2:0] q2[$];
    logic [2:0] q4[$];

    comp2_w #(.WIDTH(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .g    (g),
        .e    (e),
        .l    (l)
    );

    comp2_w #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a4),
        .b    (b4),
        .g    (g4),
        .e    (e4),
        .l    (l4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer compare, result as {g,e,l}
    function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Apply a pair at the falling edge; its result is due after the next rising edge
    task automatic drive2(input logic [1:0] x, input logic [1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        q2.push_back(ref_cmp(x, y));
    endtask

    task automatic drive4(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a4 = x;
        b4 = y;
        q4.push_back(ref_cmp(x, y));
    endtask

    // Monitors: one expectation consumed per rising edge while any are pending
    always @(posedge clk) begin
        #1;
        if (q2.size() > 0) begin
            check("cmp_w2", {29'd0, g, e, l}, {29'd0, q2.pop_front()});
        end
    end

    always @(posedge clk) begin
        #1;
        if (q4.size() > 0) begin
            check("cmp_w4", {29'd0, g4, e4, l4}, {29'd0, q4.pop_front()});
        end
    end

    // Bench-side one-hot watch on both instances
    always @(negedge clk) begin
        check("onehot_w2", {31'd0, $onehot({g, e, l})}, 32'd1);
        check("onehot_w4", {31'd0, $onehot({g4, e4, l4})}, 32'd1);
    end

    initial begin
        rst_n = 1'b1;
        a = '0;
        b = '0;
        a4 = '0;
        b4 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_w2", {29'd0, g, e, l}, 32'b010);
        check("reset_w4", {29'd0, g4, e4, l4}, 32'b010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive WIDTH=2, each pair held two cycles
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                drive2(2'(i), 2'(j));
                drive2(2'(i), 2'(j));
            end
        end

        // Latency: change inputs just after an edge; output holds until the next one
        @(posedge clk);
        #2;
        a = 2'd3;
        b = 2'd0;
        q2.push_back(ref_cmp(3, 0));
        @(negedge clk);
        check("latency_hold", {29'd0, g, e, l}, 32'b010);
        @(posedge clk);
        #2;
        check("latency_g", {31'd0, g}, 32'd1);

        // MSB dominance
        drive2(2'b10, 2'b01);
        drive2(2'b01, 2'b10);
        drive2(2'b01, 2'b10);

        // Asynchronous reset mid-cycle with g set
        drive2(2'd3, 2'd1);
        drive2(2'd3, 2'd1);
        @(posedge clk);
        #3;
        check("pre_reset_g", {29'd0, g, e, l}, 32'b100);
        rst_n = 1'b0;
        #1;
        check("async_reset", {29'd0, g, e, l}, 32'b010);
        @(posedge clk);
        #1;
        check("reset_hold", {29'd0, g, e, l}, 32'b010);
        @(negedge clk);
        rst_n = 1'b1;
        q2.push_back(ref_cmp(3, 1));
        #1;
        check("release_no_edge", {29'd0, g, e, l}, 32'b010);
        @(posedge clk);
        #2;

        // WIDTH=4: boundaries then random sweep
        drive4(4'd0, 4'd0);
        drive4(4'd15, 4'd0);
        drive4(4'd0, 4'd15);
        drive4(4'd15, 4'd15);
        drive4(4'b1000, 4'b0111);
        for (int k = 0; k < 1000; k++) begin
            drive4(4'($urandom), 4'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        check("q2_drained", q2.size(), 32'd0);
        check("q4_drained", q4.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_comp2_w
